// File: rtl/wishbone_lsu.sv
// ---------------------------------------------------------------------------
// wishbone_lsu
//   Load/store unit that turns one core access request into a single
//   Wishbone classic bus cycle. Handles byte/half/word(/double) sizes,
//   lane steering of store data, lane extraction plus sign/zero extension
//   of load data, alignment faults and bus errors.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     defined   : a BUS-state cycle counter aborts a cycle after TIMEOUT
//                 clocks without ACK_I/ERR_I and reports it as a bus error.
//     undefined : no counter; BUS waits indefinitely for ACK_I/ERR_I.
//
// Parameters
//   AW       address width in bits
//   DW       data width in bits (32 or 64)
//   TIMEOUT  bus-cycle abort limit in clocks (only with LSU_TIMEOUT_EN)
//
// Ports
//   CLK_I, RST_I          clock, asynchronous active-low reset
//   I_req, I_we, I_size,  core request (sampled only while idle)
//   I_unsigned, I_addr,
//   I_wdata
//   O_busy                state is not IDLE
//   O_done                one-cycle completion pulse
//   O_rdata               extended load data, valid with O_done
//   O_misaligned          alignment fault qualifier, valid with O_done
//   O_buserr              bus error / timeout qualifier, valid with O_done
//   CYC_O .. ERR_I        Wishbone classic master interface
// ---------------------------------------------------------------------------
module wishbone_lsu #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            I_req,
  input  logic            I_we,
  input  logic [1:0]      I_size,
  input  logic            I_unsigned,
  input  logic [AW-1:0]   I_addr,
  input  logic [DW-1:0]   I_wdata,
  output logic            O_busy,
  output logic            O_done,
  output logic [DW-1:0]   O_rdata,
  output logic            O_misaligned,
  output logic            O_buserr,
  output logic            CYC_O,
  output logic            STB_O,
  output logic            WE_O,
  output logic [DW/8-1:0] SEL_O,
  output logic [AW-1:0]   ADR_O,
  output logic [DW-1:0]   DAT_O,
  input  logic [DW-1:0]   DAT_I,
  input  logic            ACK_I,
  input  logic            ERR_I
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam bit CFG_OK = (TIMEOUT >= 1) && ((DW == 32) || (DW == 64));

  if (!CFG_OK) begin : g_cfg_check
    $error("wishbone_lsu: DW must be 32 or 64 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           misaligned_reg;
  logic           buserr_reg;
  logic [DW-1:0]  rdata_reg;
  logic           cyc_reg;
  logic           stb_reg;
  logic           we_reg;
  logic [NB-1:0]  sel_reg;
  logic [AW-1:0]  adr_reg;
  logic [DW-1:0]  dat_o_reg;

  // Request attributes kept for the load-data return path.
  logic [1:0]     size_reg;
  logic           unsigned_reg;
  logic [LB-1:0]  lane_reg;

  // ---------------------------------------------------------------------
  // Request decode (from live core inputs, used only on the IDLE edge)
  // ---------------------------------------------------------------------
  logic [LB-1:0]  req_lane;
  logic [3:0]     req_bytes;
  logic           misaligned_next;
  logic [NB-1:0]  sel_next;
  logic [DW-1:0]  wdata_masked;
  logic [DW-1:0]  dat_o_next;
  logic [AW-1:0]  adr_next;

  assign req_lane = I_addr[LB-1:0];

  always_comb begin
    req_bytes = 4'd1;
    case (I_size)
      2'b00:   req_bytes = 4'd1;
      2'b01:   req_bytes = 4'd2;
      2'b10:   req_bytes = 4'd4;
      default: req_bytes = 4'd8;
    endcase
  end

  // A double access on a 32-bit bus can never be served, so it is folded
  // into the alignment fault instead of being a separate error class.
  always_comb begin
    misaligned_next = 1'b0;
    case (I_size)
      2'b00:   misaligned_next = 1'b0;
      2'b01:   misaligned_next = I_addr[0];
      2'b10:   misaligned_next = |I_addr[1:0];
      default: misaligned_next = (DW == 32) ? 1'b1 : |I_addr[2:0];
    endcase
  end

  // Byte enable for lane gi: inside [lane, lane + bytes).
  for (genvar gi = 0; gi < NB; gi++) begin : g_sel
    assign sel_next[gi] = (gi >= int'(req_lane)) &&
                          (gi < int'(req_lane) + int'(req_bytes));
  end

  // Keep unselected lanes clean by dropping store bits above the size.
  always_comb begin
    wdata_masked = I_wdata;
    case (I_size)
      2'b00:   wdata_masked = DW'(I_wdata[7:0]);
      2'b01:   wdata_masked = DW'(I_wdata[15:0]);
      2'b10:   wdata_masked = DW'(I_wdata[31:0]);
      default: wdata_masked = I_wdata;
    endcase
  end

  assign dat_o_next = wdata_masked << {req_lane, 3'b000};
  assign adr_next   = {I_addr[AW-1:LB], {LB{1'b0}}};

  // ---------------------------------------------------------------------
  // Load return path: shift addressed lanes down, then extend
  // ---------------------------------------------------------------------
  logic [DW-1:0] lane_data;
  logic [DW-1:0] load_ext;
  logic          sign_bit;

  assign lane_data = DAT_I >> {lane_reg, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    case (size_reg)
      2'b00:   sign_bit = ~unsigned_reg & lane_data[7];
      2'b01:   sign_bit = ~unsigned_reg & lane_data[15];
      2'b10:   sign_bit = ~unsigned_reg & lane_data[31];
      default: sign_bit = 1'b0;
    endcase
    load_ext = {DW{sign_bit}};
    case (size_reg)
      2'b00:   load_ext[7:0]  = lane_data[7:0];
      2'b01:   load_ext[15:0] = lane_data[15:0];
      2'b10:   load_ext[31:0] = lane_data[31:0];
      default: load_ext       = lane_data;
    endcase
  end

  // ---------------------------------------------------------------------
  // Optional bus-cycle watchdog
  // ---------------------------------------------------------------------
  logic timeout_hit;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_reg;
  // Counter holds the number of completed BUS cycles; firing at TIMEOUT-1
  // ends the access on the edge that closes the TIMEOUT-th BUS cycle.
  assign timeout_hit = (state_reg == BUS) && (tmo_cnt_reg == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      misaligned_reg <= 1'b0;
      buserr_reg     <= 1'b0;
      rdata_reg      <= '0;
      cyc_reg        <= 1'b0;
      stb_reg        <= 1'b0;
      we_reg         <= 1'b0;
      sel_reg        <= '0;
      adr_reg        <= '0;
      dat_o_reg      <= '0;
      size_reg       <= 2'b00;
      unsigned_reg   <= 1'b0;
      lane_reg       <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (I_req) begin
            busy_reg <= 1'b1;
            if (misaligned_next) begin
              state_reg      <= DONE;
              done_reg       <= 1'b1;
              misaligned_reg <= 1'b1;
              rdata_reg      <= '0;
            end else begin
              state_reg    <= BUS;
              cyc_reg      <= 1'b1;
              stb_reg      <= 1'b1;
              we_reg       <= I_we;
              sel_reg      <= sel_next;
              adr_reg      <= adr_next;
              dat_o_reg    <= dat_o_next;
              size_reg     <= I_size;
              unsigned_reg <= I_unsigned;
              lane_reg     <= req_lane;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_reg  <= '0;
`endif
            end
          end
        end

        BUS: begin
          if (ERR_I || ACK_I || timeout_hit) begin
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            cyc_reg    <= 1'b0;
            stb_reg    <= 1'b0;
            we_reg     <= 1'b0;
            sel_reg    <= '0;
            adr_reg    <= '0;
            dat_o_reg  <= '0;
            // ERR_I takes priority; a watchdog expiry counts only when the
            // slave stayed silent on this edge.
            buserr_reg <= ERR_I || !ACK_I;
            rdata_reg  <= (!ERR_I && ACK_I && !we_reg) ? load_ext : '0;
          end
`ifdef LSU_TIMEOUT_EN
          else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end

        DONE: begin
          state_reg      <= IDLE;
          busy_reg       <= 1'b0;
          done_reg       <= 1'b0;
          misaligned_reg <= 1'b0;
          buserr_reg     <= 1'b0;
          rdata_reg      <= '0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          cyc_reg   <= 1'b0;
          stb_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign O_busy       = busy_reg;
  assign O_done       = done_reg;
  assign O_rdata      = rdata_reg;
  assign O_misaligned = misaligned_reg;
  assign O_buserr     = buserr_reg;
  assign CYC_O        = cyc_reg;
  assign STB_O        = stb_reg;
  assign WE_O         = we_reg;
  assign SEL_O        = sel_reg;
  assign ADR_O        = adr_reg;
  assign DAT_O        = dat_o_reg;

endmodule

// File: tb/tb_wishbone_lsu.sv
// ---------------------------------------------------------------------------
// tb_wishbone_lsu
//   Self-checking bench for wishbone_lsu (AW=32, DW=32, TIMEOUT=4).
//   Directed accesses followed by randomized ones; expected bus fields and
//   load results come from a byte-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_wishbone_lsu;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        I_req = 1'b0;
  logic        I_we = 1'b0;
  logic [1:0]  I_size = 2'b00;
  logic        I_unsigned = 1'b0;
  logic [31:0] I_addr = '0;
  logic [31:0] I_wdata = '0;
  logic        O_busy, O_done, O_misaligned, O_buserr;
  logic [31:0] O_rdata;
  logic        CYC_O, STB_O, WE_O;
  logic [3:0]  SEL_O;
  logic [31:0] ADR_O, DAT_O;
  logic [31:0] DAT_I = '0;
  logic        ACK_I = 1'b0;
  logic        ERR_I = 1'b0;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  wishbone_lsu #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .I_req(I_req), .I_we(I_we), .I_size(I_size), .I_unsigned(I_unsigned),
    .I_addr(I_addr), .I_wdata(I_wdata),
    .O_busy(O_busy), .O_done(O_done), .O_rdata(O_rdata),
    .O_misaligned(O_misaligned), .O_buserr(O_buserr),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .SEL_O(SEL_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d, t=%0t)", tag, got, exp, txn, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    if (nbytes(size) >= 4) return 32'hFFFF_FFFF;
    return (32'd1 << (8 * nbytes(size))) - 32'd1;
  endfunction

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] s;
    s = ((32'd1 << nbytes(size)) - 32'd1) << (addr % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_dat(input logic [1:0] size, input logic [31:0] addr,
                                            input logic [31:0] wdata);
    return (wdata & size_mask(size)) << (8 * (addr % 4));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] dati);
    logic [31:0] v;
    int nb;
    nb = nbytes(size);
    v  = (dati >> (8 * (addr % 4))) & size_mask(size);
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~size_mask(size);
    return v;
  endfunction

  // ---------------- one access with a behavioural slave ----------------
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] dati, input int waits,
                         input logic ack, input logic err);
    logic        mis;
    logic [3:0]  esel;
    logic [31:0] eadr, edat, erd;
    logic        ebe;
    txn++;
    mis  = model_mis(size, addr);
    esel = model_sel(size, addr);
    eadr = addr & 32'hFFFF_FFFC;
    edat = model_dat(size, addr, wdata);
    ebe  = err;
    erd  = (err || we) ? 32'd0 : model_load(size, uns, addr, dati);

    I_req = 1'b1; I_we = we; I_size = size; I_unsigned = uns;
    I_addr = addr; I_wdata = wdata;
    tick();

    if (mis) begin
      I_req = 1'b0;
      check_eq("mis_done", O_done, 1);
      check_eq("mis_flag", O_misaligned, 1);
      check_eq("mis_cyc", CYC_O, 0);
      check_eq("mis_buserr", O_buserr, 0);
      tick();
      check_eq("mis_done_clr", O_done, 0);
      check_eq("mis_busy_clr", O_busy, 0);
      $display("txn %0d: we=%0d size=%0d addr=%h misaligned", txn, we, size, addr);
      return;
    end

    check_eq("cyc", CYC_O, 1);
    check_eq("stb", STB_O, 1);
    check_eq("we", WE_O, we);
    check_eq("sel", SEL_O, esel);
    check_eq("adr", ADR_O, eadr);
    check_eq("dat_o", DAT_O, edat);
    check_eq("busy", O_busy, 1);
    check_eq("done_early", O_done, 0);

    // Scramble the request inputs while busy; the latched cycle must not move.
    I_we = $urandom; I_size = $urandom; I_unsigned = $urandom;
    I_addr = $urandom; I_wdata = $urandom;

    for (int w = 0; w < waits; w++) begin
      DAT_I = $urandom;
      tick();
      check_eq("hold_cyc", CYC_O, 1);
      check_eq("hold_sel", SEL_O, esel);
      check_eq("hold_adr", ADR_O, eadr);
      check_eq("hold_dat", DAT_O, edat);
      check_eq("hold_done", O_done, 0);
    end

    ACK_I = ack; ERR_I = err; DAT_I = dati;
    tick();
    ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = $urandom; I_req = 1'b0;
    check_eq("end_cyc", CYC_O, 0);
    check_eq("end_stb", STB_O, 0);
    check_eq("done", O_done, 1);
    check_eq("rdata", O_rdata, erd);
    check_eq("buserr", O_buserr, ebe);
    check_eq("mis_clear", O_misaligned, 0);
    tick();
    check_eq("done_pulse", O_done, 0);
    check_eq("busy_end", O_busy, 0);
    check_eq("buserr_clr", O_buserr, 0);
    $display("txn %0d: we=%0d size=%0d uns=%0d addr=%h waits=%0d ack=%0d err=%0d rdata=%h",
             txn, we, size, uns, addr, waits, ack, err, O_rdata);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    int          r;

    #1 RST_I = 1'b0;
    #1;
    check_eq("rst_cyc", CYC_O, 0);
    check_eq("rst_busy", O_busy, 0);
    check_eq("rst_done", O_done, 0);
    check_eq("rst_sel", SEL_O, 0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    tick();

    // Directed cases
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 1'b1, 1'b0);
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 3, 1'b1, 1'b0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b1);
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h9ABC_0000, 0, 1'b1, 1'b0);
    run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 0, 1'b1, 1'b0);

    // Slave responses while idle must be ignored
    txn++;
    ACK_I = 1'b1; ERR_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
    tick();
    tick();
    ACK_I = 1'b0; ERR_I = 1'b0;
    check_eq("idle_ack_done", O_done, 0);
    check_eq("idle_ack_busy", O_busy, 0);
    check_eq("idle_ack_cyc", CYC_O, 0);
    $display("txn %0d: idle ACK/ERR ignored", txn);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b11)
        ad = ad & ~(32'(nbytes(sz)) - 32'd1);
      r = $urandom_range(0, 15);
      run_txn(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom,
              $urandom_range(0, 3), (r != 0), (r <= 2));
    end

`ifdef LSU_TIMEOUT_EN
    // Silent slave: watchdog closes the cycle after 4 BUS cycles
    txn++;
    I_req = 1'b1; I_we = 1'b0; I_size = 2'b10; I_addr = 32'h40; I_unsigned = 1'b0;
    tick();
    I_req = 1'b0;
    check_eq("tmo_cyc1", CYC_O, 1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_eq("tmo_cyc_hold", CYC_O, 1);
      check_eq("tmo_no_done", O_done, 0);
    end
    tick();
    check_eq("tmo_cyc_drop", CYC_O, 0);
    check_eq("tmo_done", O_done, 1);
    check_eq("tmo_buserr", O_buserr, 1);
    check_eq("tmo_rdata", O_rdata, 0);
    tick();
    check_eq("tmo_done_clr", O_done, 0);
    $display("txn %0d: timeout abort", txn);
`else
    // Without the watchdog a long wait still completes normally
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 12, 1'b1, 1'b0);
`endif

    // Reset asserted in cycle 2 of a bus cycle
    txn++;
    I_req = 1'b1; I_we = 1'b1; I_size = 2'b10; I_addr = 32'h80; I_wdata = 32'h5555_AAAA;
    tick();
    I_req = 1'b0;
    check_eq("rstmid_cyc1", CYC_O, 1);
    tick();
    #2 RST_I = 1'b0;
    #1;
    check_eq("rstmid_cyc", CYC_O, 0);
    check_eq("rstmid_stb", STB_O, 0);
    check_eq("rstmid_busy", O_busy, 0);
    check_eq("rstmid_we", WE_O, 0);
    check_eq("rstmid_dat", DAT_O, 0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    ACK_I = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      ACK_I = 1'b0;
      check_eq("rstmid_no_done", O_done, 0);
      check_eq("rstmid_no_cyc", CYC_O, 0);
    end
    $display("txn %0d: reset mid-cycle", txn);

    // Normal operation after reset
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0301, 32'h0, 32'h0000_C300, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
